// File: rtl/mux_rr_arb.sv
// N-channel arbitrating mux with a registered output stage.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1), valid/ready on both sides.
module mux_rr_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] win_idx;
  logic [NCH-1:0]   grant;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             any_valid;
  logic             can_load;

  assign any_valid = |in_valid;
  assign can_load  = ~out_valid | out_ready;

  // Scan channels starting at rr_ptr (MODE 0) or at 0 (MODE 1); first valid wins.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned and no latch is inferred.
    idx      = 0;
    grant    = '0;
    win_idx  = '0;
    win_data = '0;
    found    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = (MODE == 0) ? int'(rr_ptr) + k : k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = SEL_W'(idx);
        win_data   = in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (can_load && !reset) ? grant : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data/sel registers are reset too because their reset value is observable.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (can_load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= win_idx;
        if (MODE == 0)
          rr_ptr <= (win_idx == SEL_W'(NCH - 1)) ? '0 : win_idx + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: a MODE 0 instance checked against a queue-based
// scoreboard and constants, plus a MODE 1 instance for the fixed-priority case.
module tb_mux_rr_arb;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
  } word_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_ready;

  logic [NCH-1:0]   r0, r1;
  logic             ov0, ov1;
  logic [WIDTH-1:0] od0, od1;
  logic [SEL_W-1:0] os0, os1;

  mux_rr_arb #(.WIDTH(WIDTH), .NCH(NCH), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(r0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(out_ready)
  );

  mux_rr_arb #(.WIDTH(WIDTH), .NCH(NCH), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(r1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  word_t       sb[$];
  logic        m_valid;
  logic [1:0]  m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx(input logic [NCH-1:0] v, input logic [1:0] ptr);
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NCH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  // One clock: check handshake and outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int         gi;
    logic [3:0] exp_ready;
    word_t      w;
    @(negedge clk);
    gi        = model_idx(in_valid, m_ptr);
    exp_ready = '0;
    if (!reset && (!m_valid || out_ready) && gi >= 0) exp_ready[gi] = 1'b1;
    check("in_ready", 32'(r0), 32'(exp_ready));
    check("out_valid", 32'(ov0), 32'(m_valid));
    if (ov0 && out_ready && !reset) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("sb_data", 32'(od0), 32'(w.data));
        check("sb_sel", 32'(os0), 32'(w.sel));
      end
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_ptr   = '0;
      sb.delete();
    end else if (!m_valid || out_ready) begin
      if (gi >= 0) begin
        w.data  = in_data[gi*WIDTH +: WIDTH];
        w.sel   = SEL_W'(gi);
        sb.push_back(w);
        m_valid = 1'b1;
        m_ptr   = (gi == NCH - 1) ? 2'd0 : 2'(gi + 1);
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_ptr     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ov0), 0);
    check("rst_out_data", 32'(od0), 0);
    check("rst_out_sel", 32'(os0), 0);
    check("rst_in_ready", 32'(r0), 0);
    check("rst_out_valid_m1", 32'(ov1), 0);

    // Single request on ch1
    reset = 1'b0;
    set_ch(1, 8'h9A);
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    #1;
    check("t1_in_ready", 32'(r0), 32'h2);
    cycle();
    check("t1_out_valid", 32'(ov0), 1);
    check("t1_out_data", 32'(od0), 32'h9A);
    check("t1_out_sel", 32'(os0), 1);

    // Drain with no new request: valid drops, data holds
    in_valid = '0;
    cycle();
    check("t6_out_valid", 32'(ov0), 0);
    check("t6_out_data_hold", 32'(od0), 32'h9A);

    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // All channels valid: round-robin on dut0, fixed priority on dut1
    set_ch(0, 8'h10);
    set_ch(1, 8'h20);
    set_ch(2, 8'h30);
    set_ch(3, 8'h40);
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t2_rr_sel", 32'(os0), 32'(i % 4));
      check("t2_rr_data", 32'(od0), 32'(((i % 4) + 1) * 16));
      check("t3_fp_sel", 32'(os1), 0);
      check("t3_fp_data", 32'(od1), 32'h10);
      check("t3_fp_ready_hi", 32'(r1[3:1]), 0);
    end

    // Load ch2, then stall with ch0/ch3 pending
    in_valid = 4'b0100;
    set_ch(2, 8'h75);
    cycle();
    check("t4_load_data", 32'(od0), 32'h75);
    check("t4_load_sel", 32'(os0), 2);
    set_ch(0, 8'hA0);
    set_ch(3, 8'hC3);
    in_valid  = 4'b1001;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_stall_valid", 32'(ov0), 1);
      check("t4_stall_data", 32'(od0), 32'h75);
      check("t4_stall_sel", 32'(os0), 2);
      check("t4_stall_ready", 32'(r0), 0);
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(r0), 32'h8);
    cycle();
    check("t4_next_sel", 32'(os0), 3);
    check("t4_next_data", 32'(od0), 32'hC3);

    // Reset while holding a word with ch1 pending
    set_ch(1, 8'h5B);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    reset     = 1'b1;
    cycle();
    check("t5_rst_valid", 32'(ov0), 0);
    check("t5_rst_data", 32'(od0), 0);
    check("t5_rst_sel", 32'(os0), 0);
    reset     = 1'b0;
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    #1;
    check("t5_restart_ready", 32'(r0), 32'h1);
    cycle();
    check("t5_restart_sel", 32'(os0), 0);
    check("t5_restart_data", 32'(od0), 32'hA0);
    in_valid = 4'b0010;
    cycle();
    check("t5_next_sel", 32'(os0), 1);
    check("t5_next_data", 32'(od0), 32'h5B);
    in_valid = '0;
    cycle();
    cycle();
    check("end_out_valid", 32'(ov0), 0);
    check("end_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
